// File: rtl/rib_arbiter_pkg.sv
// Shared definitions for the RIB slave-port arbiter: state encoding, hold levels,
// master index map and a one-hot-to-index helper.
package rib_arbiter_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    localparam logic HoldEnable  = 1'b1;
    localparam logic HoldDisable = 1'b0;

    localparam int M_CORE = 0;
    localparam int M_JTAG = 1;
    localparam int M_UART = 2;

    // Supports up to eight masters; the lowest set bit wins if the input is not one-hot.
    function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (oh[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rib_arb_pick.sv
// Combinational one-hot selector: scans the request vector from start_i, upward or
// downward with wrap-around, and returns the first requester found.
module rib_arb_pick
    import rib_arbiter_pkg::*;
#(
    parameter int NUM_M = 4,
    parameter int IW    = (NUM_M > 1) ? $clog2(NUM_M) : 1
) (
    input  logic [NUM_M-1:0] req_i,
    input  logic [IW-1:0]    start_i,
    input  logic             up_i,
    output logic [NUM_M-1:0] win_o
);

    logic found;
    int   idx;

    // First requester encountered in the chosen scan direction wins.
    always_comb begin
        win_o = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NUM_M; k++) begin
            if (up_i) begin
                idx = (int'(start_i) + k) % NUM_M;
            end else begin
                idx = (int'(start_i) - k + NUM_M) % NUM_M;
            end
            if (!found && req_i[idx]) begin
                win_o[idx] = 1'b1;
                found      = 1'b1;
            end else begin
                found = found;
            end
        end
    end

endmodule

// File: rtl/rib_arbiter.sv
// Shares the RIB slave port between NUM_M masters with a grant locked until ack or timeout.
// Define RIB_ARB_RR_EN for round-robin arbitration; otherwise highest index wins.
module rib_arbiter
    import rib_arbiter_pkg::*;
#(
    parameter int NUM_M       = 4,
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_M-1:0]    m_req_i,
    input  logic [NUM_M*AW-1:0] m_addr_i,
    input  logic [NUM_M*DW-1:0] m_data_i,
    input  logic [NUM_M-1:0]    m_we_i,
    output logic [NUM_M-1:0]    m_ack_o,
    output logic [DW-1:0]       m_data_o,
    output logic                m_err_o,
    output logic                s_req_o,
    output logic [AW-1:0]       s_addr_o,
    output logic [DW-1:0]       s_data_o,
    output logic                s_we_o,
    input  logic                s_ack_i,
    input  logic [DW-1:0]       s_data_i,
    output logic [NUM_M-1:0]    grant_o,
    output logic                hold_flag_o
);

    localparam int IW = (NUM_M > 1) ? $clog2(NUM_M) : 1;
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    arb_state_e       state_q, state_d;
    logic [NUM_M-1:0] grant_q, grant_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [NUM_M-1:0] win_s;
    logic [IW-1:0]    start_s;
    logic             up_s;
    logic             busy_s, timeout_s, done_s;

`ifdef RIB_ARB_RR_EN
    // ptr_q holds the index following the last completed grant, i.e. where the next scan starts.
    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] g_idx_s;
    assign g_idx_s = IW'(onehot_to_idx(8'(grant_q)));
    assign start_s = ptr_q;
    assign up_s    = 1'b1;
`else
    assign start_s = IW'(NUM_M - 1);
    assign up_s    = 1'b0;
`endif

    rib_arb_pick #(.NUM_M(NUM_M), .IW(IW)) u_pick (
        .req_i   (m_req_i),
        .start_i (start_s),
        .up_i    (up_s),
        .win_o   (win_s)
    );

    assign busy_s    = (state_q == ARB_BUSY);
    assign timeout_s = busy_s && (cnt_q == CW'(TIMEOUT_CYC));
    assign done_s    = busy_s && (s_ack_i || timeout_s);

    assign s_req_o     = busy_s;
    assign grant_o     = grant_q;
    assign m_ack_o     = grant_q & {NUM_M{done_s}};
    assign m_err_o     = timeout_s && !s_ack_i;
    assign m_data_o    = (busy_s && s_ack_i) ? s_data_i : '0;
    assign hold_flag_o = (m_req_i[M_CORE] && !(grant_q[M_CORE] && s_ack_i)) ? HoldEnable : HoldDisable;

    // AND-OR mux of the granted master's request fields; all zero while idle.
    always_comb begin
        s_addr_o = '0;
        s_data_o = '0;
        s_we_o   = 1'b0;
        for (int i = 0; i < NUM_M; i++) begin
            s_addr_o = s_addr_o | (m_addr_i[i*AW +: AW] & {AW{grant_q[i]}});
            s_data_o = s_data_o | (m_data_i[i*DW +: DW] & {DW{grant_q[i]}});
            s_we_o   = s_we_o   | (m_we_i[i] & grant_q[i]);
        end
    end

    // Next-state logic for the IDLE/BUSY handshake and the timeout counter.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        cnt_d   = cnt_q;
`ifdef RIB_ARB_RR_EN
        ptr_d   = ptr_q;
`endif
        case (state_q)
            ARB_IDLE: begin
                if (|m_req_i) begin
                    grant_d = win_s;
                    cnt_d   = '0;
                    state_d = ARB_BUSY;
                end else begin
                    grant_d = '0;
                end
            end
            ARB_BUSY: begin
                if (done_s) begin
                    state_d = ARB_IDLE;
                    grant_d = '0;
                    cnt_d   = '0;
`ifdef RIB_ARB_RR_EN
                    ptr_d   = (g_idx_s == IW'(NUM_M - 1)) ? '0 : g_idx_s + IW'(1);
`endif
                end else begin
                    // Completion fires at TIMEOUT_CYC, so this increment cannot wrap.
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = ARB_IDLE;
                grant_d = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            cnt_q   <= '0;
`ifdef RIB_ARB_RR_EN
            ptr_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
`ifdef RIB_ARB_RR_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

endmodule
